// File: rtl/softmax_ctrl.sv
// softmax_ctrl: packs 10 logits, fires the softmax datapath, argmax-scans the returned probabilities.
// Optional response watchdog with sticky err port when SMC_TIMEOUT_EN is defined.
module softmax_ctrl #(
  parameter int N_CLASS = 10
`ifdef SMC_TIMEOUT_EN
  , parameter int TIMEOUT = 15
`endif
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_data,
  output logic                     sm_valid_in,
  output logic [N_CLASS-1:0][31:0] sm_d_in,
  input  logic                     sm_valid_out,
  input  logic [N_CLASS-1:0][31:0] sm_percent,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_idx,
  output logic [31:0]              out_prob,
  output logic [N_CLASS-1:0][31:0] out_vec
`ifdef SMC_TIMEOUT_EN
  , output logic                   err
`endif
);
  typedef enum logic [2:0] {COLLECT, FIRE, WAIT, SCAN, DONE} state_t;
  state_t r_state, w_next;
  logic [3:0] r_cnt, r_i, r_best_idx;
  logic [N_CLASS-1:0][31:0] r_lbuf, r_pbuf;
  logic [31:0] r_best;
  logic w_acc, w_cap, w_to;
  assign w_acc = in_valid && in_ready;
  assign w_cap = r_state == WAIT && sm_valid_out;
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) r_state <= COLLECT;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      COLLECT: if (w_acc && r_cnt == 4'(N_CLASS - 1)) w_next = FIRE;
      FIRE:    w_next = WAIT;
      WAIT:    w_next = sm_valid_out ? SCAN : (w_to ? COLLECT : WAIT);
      SCAN:    if (r_i == 4'(N_CLASS - 1)) w_next = DONE;
      DONE:    if (out_ready) w_next = COLLECT;
      default: w_next = COLLECT;
    endcase
  end
  always_comb begin
    in_ready    = r_state == COLLECT;
    sm_valid_in = r_state == FIRE;
    out_valid   = r_state == DONE;
  end
  // Magnitude-only compare: probabilities are non-negative, strict > keeps the lowest index on ties
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_cnt      <= '0;
      r_i        <= '0;
      r_best_idx <= '0;
      r_best     <= '0;
      r_lbuf     <= '0;
      r_pbuf     <= '0;
    end else begin
      if (w_acc) begin
        r_lbuf[r_cnt] <= in_data;
        r_cnt         <= r_cnt == 4'(N_CLASS - 1) ? 4'd0 : r_cnt + 4'd1;
      end
      if (w_cap) begin
        r_pbuf     <= sm_percent;
        r_best     <= sm_percent[0];
        r_best_idx <= 4'd0;
        r_i        <= 4'd1;
      end
      if (r_state == SCAN) begin
        if (r_pbuf[r_i][30:0] > r_best[30:0]) begin
          r_best     <= r_pbuf[r_i];
          r_best_idx <= r_i;
        end
        r_i <= r_i + 4'd1;
      end
    end
  end
`ifdef SMC_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] r_wcnt;
  logic r_err;
  assign w_to = r_wcnt == WW'(TIMEOUT - 1);
  assign err = r_err;
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_wcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      r_wcnt <= r_state == WAIT ? r_wcnt + 1'b1 : '0;
      if (r_state == WAIT && !sm_valid_out && w_to) r_err <= 1'b1;
    end
  end
`else
  assign w_to = 1'b0;
`endif
  assign sm_d_in  = r_lbuf;
  assign out_vec  = r_pbuf;
  assign out_prob = r_best;
  assign out_idx  = r_best_idx;
endmodule

// File: tb/tb_softmax_ctrl.sv
// tb_softmax_ctrl: randomized self-checking bench for softmax_ctrl with a behavioural argmax model.
module tb_softmax_ctrl;
  localparam int N = 10;
  typedef logic [N-1:0][31:0] vec_t;
  logic clk = 0, resetn = 1, in_valid = 0, sm_valid_out = 0, out_ready = 0;
  logic in_ready, sm_valid_in, out_valid;
  logic [31:0] in_data = 0, out_prob;
  vec_t sm_d_in, out_vec, sm_percent = '0;
  logic [3:0] out_idx;
`ifdef SMC_TIMEOUT_EN
  logic err;
`endif
  int n_chk = 0, n_fail = 0, acc_cnt = 0, fire_cnt = 0, ov_cnt = 0;
  logic [31:0] w[N], p[N];

  softmax_ctrl dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sm_valid_in(sm_valid_in), .sm_d_in(sm_d_in), .sm_valid_out(sm_valid_out), .sm_percent(sm_percent),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_prob(out_prob), .out_vec(out_vec)
`ifdef SMC_TIMEOUT_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
    if (sm_valid_in) fire_cnt <= fire_cnt + 1;
    if (out_valid) ov_cnt <= ov_cnt + 1;
  end

  // Winner = first index holding the largest magnitude
  function automatic int argmax(input logic [31:0] a[N]);
    logic [30:0] mx = '0;
    foreach (a[i]) if (a[i][30:0] > mx) mx = a[i][30:0];
    for (int i = 0; i < N; i++) if (a[i][30:0] == mx) return i;
    return 0;
  endfunction

  function automatic vec_t pack(input logic [31:0] a[N]);
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = a[i];
    return v;
  endfunction

  // Sends 10 words (toggling in_valid when bp), answers with capture at edge T0+cap (cap=0: never),
  // returns edges from the 10th accept to out_valid seen high
  task automatic run_vec(input logic [31:0] wv[N], input logic [31:0] pv[N], input bit bp, input int cap,
                         output int lat, output bit fire_ok);
    int k = 0, g = 0;
    lat = 0;
    while (k < N && g < 200) begin
      @(negedge clk);
      in_valid = bp ? !in_valid : 1'b1;
      in_data = in_valid ? wv[k] : $urandom;
      if (in_valid && in_ready) k++;
      g++;
    end
    @(negedge clk);
    in_valid = bp;
    in_data = $urandom;
    fire_ok = sm_valid_in;
    @(negedge clk);
    fire_ok = fire_ok && !sm_valid_in && !in_ready;
    if (cap > 0) begin
      repeat (cap - 2) @(negedge clk);
      sm_valid_out = 1;
      for (int i = 0; i < N; i++) sm_percent[i] = pv[i];
      @(negedge clk);
      sm_valid_out = 0;
      for (int i = 0; i < N; i++) sm_percent[i] = $urandom;
      lat = cap;
      while (!out_valid && lat < cap + 40) begin
        @(negedge clk);
        lat++;
      end
    end
    in_valid = 0;
  endtask

  task automatic test_reset();
    resetn = 1;
    repeat (2) @(negedge clk);
    n_chk++; if (in_ready !== 1'b1 || sm_valid_in !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl: in_ready=%b sm_valid_in=%b out_valid=%b want 1 0 0", in_ready, sm_valid_in, out_valid); end
    n_chk++; if (out_idx !== 4'd0 || out_prob !== 32'd0) begin n_fail++; $display("FAIL reset_result: idx=%0d prob=%h want 0 0", out_idx, out_prob); end
    n_chk++; if (out_vec !== '0 || sm_d_in !== '0) begin n_fail++; $display("FAIL reset_vectors: out_vec/sm_d_in not zero"); end
`ifdef SMC_TIMEOUT_EN
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
`endif
    resetn = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, f0; bit fok; vec_t ew; logic [3:0] ei;
    for (int i = 0; i < N; i++) begin w[i] = $urandom; p[i] = (i == 6) ? 32'h3F0CCCCD : 32'h3D4CCCCD; end
    ew = pack(w); ei = 4'(argmax(p)); f0 = fire_cnt;
    run_vec(w, p, 0, 6, lat, fok);
    n_chk++; if (fok !== 1'b1) begin n_fail++; $display("FAIL basic_fire: sm_valid_in pulse shape got %b want 1", fok); end
    n_chk++; if (sm_d_in !== ew) begin n_fail++; $display("FAIL basic_d_in: got %h want %h", sm_d_in, ew); end
    n_chk++; if (lat != 15) begin n_fail++; $display("FAIL basic_latency: got %0d want 15", lat); end
    n_chk++; if (out_idx !== ei) begin n_fail++; $display("FAIL basic_idx: got %0d want %0d", out_idx, ei); end
    n_chk++; if (out_prob !== p[ei]) begin n_fail++; $display("FAIL basic_prob: got %h want %h", out_prob, p[ei]); end
    n_chk++; if (out_vec !== pack(p)) begin n_fail++; $display("FAIL basic_vec: got %h want %h", out_vec, pack(p)); end
    n_chk++; if (fire_cnt - f0 != 1) begin n_fail++; $display("FAIL basic_fire_count: got %0d want 1", fire_cnt - f0); end
    out_ready = 1;
    @(negedge clk);
    n_chk++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
    out_ready = 0;
  endtask

  task automatic test_tie();
    int lat; bit fok; logic [3:0] ei;
    for (int i = 0; i < N; i++) begin w[i] = $urandom; p[i] = (i == 2 || i == 7) ? 32'h3ECCCCCD : 32'h3CCCCCCD; end
    ei = 4'(argmax(p));
    out_ready = 1;
    run_vec(w, p, 0, 6, lat, fok);
    n_chk++; if (out_idx !== ei || out_prob !== p[ei]) begin n_fail++; $display("FAIL tie_idx: got %0d/%h want %0d/%h", out_idx, out_prob, ei, p[ei]); end
    n_chk++; if (lat != 15) begin n_fail++; $display("FAIL tie_latency: got %0d want 15", lat); end
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL tie_one_cycle_done: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
    out_ready = 0;
  endtask

  task automatic test_backpressure();
    int lat, a0, bad = 0; bit fok; logic [3:0] ei; vec_t ev;
    for (int i = 0; i < N; i++) begin w[i] = $urandom; p[i] = {1'b0, 31'($urandom_range(0, 32'h3F7FFFFF))}; end
    ei = 4'(argmax(p)); ev = pack(p); a0 = acc_cnt;
    run_vec(w, p, 1, 6, lat, fok);
    n_chk++; if (fok !== 1'b1 || sm_d_in !== pack(w)) begin n_fail++; $display("FAIL bp_collect: fire=%b d_in=%h want 1 %h", fok, sm_d_in, pack(w)); end
    n_chk++; if (lat != 15) begin n_fail++; $display("FAIL bp_latency: got %0d want 15", lat); end
    for (int c = 0; c < 20; c++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_idx !== ei || out_prob !== p[ei] || out_vec !== ev) bad++;
      in_valid = 1; in_data = $urandom; sm_valid_out = 1'($urandom);
      for (int i = 0; i < N; i++) sm_percent[i] = $urandom;
      @(negedge clk);
    end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold_stable: %0d unstable cycles want 0", bad); end
    n_chk++; if (acc_cnt - a0 != 10) begin n_fail++; $display("FAIL bp_accepts: got %0d want 10", acc_cnt - a0); end
    in_valid = 0; sm_valid_out = 0; out_ready = 1;
    @(negedge clk);
    n_chk++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
    out_ready = 0;
  endtask

  task automatic test_stray();
    int f0 = fire_cnt, o0 = ov_cnt, lat; bit fok; vec_t ev = out_vec; logic [3:0] ei;
    for (int c = 0; c < 5; c++) begin
      sm_valid_out = 1;
      for (int i = 0; i < N; i++) sm_percent[i] = $urandom;
      @(negedge clk);
    end
    sm_valid_out = 0;
    @(negedge clk);
    n_chk++; if (out_vec !== ev) begin n_fail++; $display("FAIL stray_pbuf: got %h want %h", out_vec, ev); end
    n_chk++; if (fire_cnt != f0 || ov_cnt != o0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL stray_state: fires=%0d outs=%0d in_ready=%b want 0 0 1", fire_cnt - f0, ov_cnt - o0, in_ready); end
    for (int i = 0; i < N; i++) begin w[i] = $urandom; p[i] = $urandom; end
    ei = 4'(argmax(p));
    run_vec(w, p, 0, 6, lat, fok);
    n_chk++; if (out_idx !== ei || out_vec !== pack(p) || lat != 15) begin n_fail++; $display("FAIL stray_followup: idx=%0d lat=%0d want %0d 15", out_idx, lat, ei); end
    out_ready = 1; @(negedge clk); out_ready = 0;
  endtask

  task automatic test_random();
    int lat, a, b; bit fok, ordy; logic [3:0] ei;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++) begin w[i] = $urandom; p[i] = {1'($urandom), 31'($urandom_range(0, 32'h3F000000))}; end
      if ($urandom_range(0, 1) == 1) begin
        a = $urandom_range(0, N - 2); b = $urandom_range(a + 1, N - 1);
        p[a] = {1'($urandom), 31'h3F800000}; p[b] = {1'($urandom), 31'h3F800000};
      end
      ei = 4'(argmax(p)); ordy = 1'($urandom); out_ready = ordy;
      run_vec(w, p, 1'($urandom), 6, lat, fok);
      n_chk++; if (out_idx !== ei || out_prob !== p[ei]) begin n_fail++; $display("FAIL rand_result[%0d]: got %0d/%h want %0d/%h", t, out_idx, out_prob, ei, p[ei]); end
      n_chk++; if (lat != 15 || fok !== 1'b1 || sm_d_in !== pack(w)) begin n_fail++; $display("FAIL rand_timing[%0d]: lat=%0d fire=%b want 15 1", t, lat, fok); end
      out_ready = 1; @(negedge clk); out_ready = 0;
    end
  endtask

  task automatic test_mid_reset();
    int lat; bit fok; logic [3:0] ei;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1; in_data = $urandom | 32'h1;
    end
    @(negedge clk);
    in_valid = 0;
    resetn = 1;
    #1;
    n_chk++; if (in_ready !== 1'b1 || sm_valid_in !== 1'b0 || out_valid !== 1'b0 || out_idx !== 4'd0 || out_prob !== 32'd0) begin n_fail++; $display("FAIL midreset_ctrl: in_ready=%b out_valid=%b idx=%0d prob=%h want 1 0 0 0", in_ready, out_valid, out_idx, out_prob); end
    n_chk++; if (sm_d_in !== '0 || out_vec !== '0) begin n_fail++; $display("FAIL midreset_vectors: got d_in=%h want 0", sm_d_in); end
    @(negedge clk);
    resetn = 0;
    for (int i = 0; i < N; i++) begin w[i] = $urandom; p[i] = $urandom; end
    ei = 4'(argmax(p));
    run_vec(w, p, 0, 6, lat, fok);
    n_chk++; if (sm_d_in !== pack(w)) begin n_fail++; $display("FAIL midreset_fresh: got %h want %h", sm_d_in, pack(w)); end
    n_chk++; if (out_idx !== ei || out_prob !== p[ei] || lat != 15) begin n_fail++; $display("FAIL midreset_result: idx=%0d lat=%0d want %0d 15", out_idx, lat, ei); end
    out_ready = 1; @(negedge clk); out_ready = 0;
  endtask

`ifdef SMC_TIMEOUT_EN
  task automatic test_timeout();
    int lat, o0; bit fok; logic [3:0] ei;
    for (int i = 0; i < N; i++) begin w[i] = $urandom; p[i] = $urandom; end
    ei = 4'(argmax(p));
    run_vec(w, p, 0, 16, lat, fok);
    n_chk++; if (lat != 25 || out_idx !== ei || err !== 1'b0) begin n_fail++; $display("FAIL to_last_cycle: lat=%0d idx=%0d err=%b want 25 %0d 0", lat, out_idx, err, ei); end
    out_ready = 1; @(negedge clk); out_ready = 0;
    o0 = ov_cnt;
    run_vec(w, p, 0, 0, lat, fok);
    repeat (14) @(negedge clk);
    n_chk++; if (err !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL to_early: err=%b in_ready=%b want 0 0", err, in_ready); end
    @(negedge clk);
    n_chk++; if (err !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL to_fire: err=%b in_ready=%b out_valid=%b want 1 1 0", err, in_ready, out_valid); end
    repeat (12) @(negedge clk);
    n_chk++; if (ov_cnt != o0 || err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: outs=%0d err=%b want 0 1", ov_cnt - o0, err); end
    resetn = 1; @(negedge clk); resetn = 0; @(negedge clk);
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL to_clear: err=%b want 0", err); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_backpressure();
    test_stray();
    test_random();
    test_mid_reset();
`ifdef SMC_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/softmax_ctrl.md
# softmax_ctrl

Sequencer for the 10-class softmax stage at the tail of the classifier. It accepts the logits one word at a time from the upstream fully-connected layer and packs them into a vector. It then fires the softmax datapath and waits for its result. It scans the returned probabilities for the winning class and presents index, probability and the full vector downstream over a valid/ready handshake.

## Interface
- N_CLASS, 10: number of classes. Fixed at 10 to match the softmax datapath vector width.
- TIMEOUT, 15: watchdog limit, in cycles, for the softmax response. Used only with SMC_TIMEOUT_EN.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- resetn  in  1  reset, asynchronous and active-high (1 = reset asserted).
- in_valid  in  1  upstream logit word valid.
- in_ready  out  1  block can accept a logit word.
- in_data  in  32  IEEE-754 single logit.
- sm_valid_in  out  1  one-cycle start pulse to the softmax datapath.
- sm_d_in  out  32 x 10  packed logit vector to the datapath; element 0 is the first word accepted.
- sm_valid_out  in  1  datapath result-valid pulse.
- sm_percent  in  32 x 10  datapath probabilities, IEEE-754 single.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_idx  out  4  argmax class index, 0..9.
- out_prob  out  32  probability of out_idx.
- out_vec  out  32 x 10  captured probability vector.
- err  out  1  sticky timeout flag. Exists only with SMC_TIMEOUT_EN.

## Operation
- FSM states: COLLECT, FIRE, WAIT, SCAN, DONE. Reset state is COLLECT.
- COLLECT
  - in_ready=1.
  - A word is accepted when in_valid & in_ready at a rising edge. It is written to lbuf[cnt] and cnt increments.
  - On the 10th accept (cnt=9), cnt clears and the FSM goes to FIRE.
- FIRE
  - sm_valid_in=1 for exactly this one cycle. sm_d_in=lbuf, held stable in all states.
  - Next state is WAIT.
- WAIT
  - in_ready=0.
  - On the edge where sm_valid_out=1, sm_percent is latched into pbuf. best_idx=0, best=pbuf-candidate 0, i=1. Next state is SCAN.
- SCAN
  - One element per cycle, i=1..9.
  - If pbuf[i][30:0] > best[30:0] (unsigned compare), best and best_idx update.
  - Sign bit is ignored: probabilities are non-negative. NaN/Inf are not handled.
  - Strict compare, so on a tie the lowest index wins.
  - After i=9 the FSM goes to DONE.
- DONE
  - out_valid=1; out_idx, out_prob and out_vec are stable.
  - On out_valid & out_ready the FSM returns to COLLECT.
- sm_valid_out outside WAIT is ignored.
- in_valid outside COLLECT is not accepted.
- out_ready outside DONE has no effect.

## Timing
- Reset values: in_ready=1, sm_valid_in=0, out_valid=0, out_idx=0, out_prob=0, out_vec all 0, sm_d_in all 0, err=0, cnt=0.
- Reset asserted mid-operation aborts immediately. Partial vectors and pending results are discarded.
- Back-to-back words: one accepted per cycle, no bubbles. The 10th accept edge is T0.
  - sm_valid_in is high in cycle T0+1.
  - WAIT begins at T0+2.
- sm_valid_out sampled at edge E:
  - SCAN occupies E..E+9.
  - out_valid rises after edge E+9, i.e. 9 cycles after capture.
- With the 4-cycle datapath, the total from the 10th accepted word to out_valid is 15 cycles.
- out_valid can be held indefinitely. Outputs must not change while out_valid=1 & out_ready=0.
- If out_ready is already high when DONE is entered, DONE lasts one cycle and in_ready returns the next cycle.

## Configuration
- SMC_TIMEOUT_EN defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without sm_valid_out, err is set (sticky until reset) and the FSM returns to COLLECT without producing out_valid.
  - If sm_valid_out arrives on the same edge the counter reaches TIMEOUT, the result wins and err stays 0.
- SMC_TIMEOUT_EN undefined: WAIT waits forever. No counter, no err port.

## Test plan
- Basic run:
  - Stimulus: 10 back-to-back words; model returns percent = {0.05 x9, 0.55 at index 6}.
  - Response: sm_valid_in one pulse at T0+1; sm_d_in matches words in order; out_idx=6; out_prob=0x3F0CCCCD; out_valid 15 cycles after the 10th accept.
- Tie:
  - Stimulus: indices 2 and 7 both 0.4, rest 0.025.
  - Response: out_idx=2.
- Backpressure:
  - Upstream: in_valid toggles 1/0; exactly 10 accepts before FIRE, and in_ready=0 during WAIT/SCAN/DONE.
  - Downstream: out_ready held 0 for 20 cycles; outputs stable, no new accept; out_ready=1 then in_ready=1 the next cycle.
- Stray pulse:
  - Stimulus: sm_valid_out during COLLECT.
  - Response: ignored; pbuf unchanged.
- Reset mid-operation:
  - Stimulus: resetn=1 after 5 words, then a fresh 10-word vector.
  - Response: result reflects only the fresh vector; all outputs show reset values during reset.
- Timeout (with SMC_TIMEOUT_EN, TIMEOUT=15):
  - No sm_valid_out: err=1 after 15 WAIT cycles, no out_valid, in_ready=1.
  - Response on the 15th cycle: normal result, err=0.
